// File: rtl/snes_pkg.sv
// Shared definitions for the SNES poll scheduler: FSM encoding, button word width,
// button bit positions and the edge-mask helper.
package snes_pkg;

    localparam int SNES_BTN_W = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_REQ    = 3'd2,
        S_RISE   = 3'd3,
        S_BUSY   = 3'd4,
        S_UPDATE = 3'd5
    } poll_state_t;

    typedef struct packed {
        logic [SNES_BTN_W-1:0] pressed;
        logic [SNES_BTN_W-1:0] released;
    } btn_edge_t;

    function automatic btn_edge_t btn_edges(input logic [SNES_BTN_W-1:0] old_w,
                                            input logic [SNES_BTN_W-1:0] new_w);
        btn_edge_t e;
        e.pressed  = new_w & ~old_w;
        e.released = ~new_w & old_w;
        return e;
    endfunction

endpackage

// File: rtl/snes_evt_reg.sv
// Edge-event holding register: loads fresh masks when empty or being drained,
// otherwise folds new edges into the pending event so a stalled consumer sees the latest net state.
module snes_evt_reg
    import snes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [SNES_BTN_W-1:0] i_pressed,
    input  logic [SNES_BTN_W-1:0] i_released,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [SNES_BTN_W-1:0] o_pressed,
    output logic [SNES_BTN_W-1:0] o_released
);

    logic                  r_valid;
    logic [SNES_BTN_W-1:0] r_pressed;
    logic [SNES_BTN_W-1:0] r_released;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pressed  <= '0;
            r_released <= '0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_pressed  <= i_pressed;
                r_released <= i_released;
            end else begin
                // a later edge on the same bit cancels the earlier opposite edge
                r_pressed  <= (r_pressed & ~i_released) | i_pressed;
                r_released <= (r_released & ~i_pressed) | i_released;
            end
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/snes_poll_scheduler.sv
// Periodic SNES gamepad poller: launches reads on a fixed tick, captures the button word and
// publishes press/release events. `SNES_POLL_CONNECT_DETECT_EN adds pad_present detection.
module snes_poll_scheduler
    import snes_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int POLL_HZ = 60,
    parameter int TIMEOUT = 32768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  pad_rd,
    input  logic                  pad_busy,
    input  logic [SNES_BTN_W-1:0] pad_buttons,
    output logic [SNES_BTN_W-1:0] btn_state,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [SNES_BTN_W-1:0] evt_pressed,
    output logic [SNES_BTN_W-1:0] evt_released,
    output logic                  timeout_err,
`ifdef SNES_POLL_CONNECT_DETECT_EN
    output logic                  pad_present,
`endif
    output logic                  poll_done
);

    localparam int PERIOD = CLK_HZ / POLL_HZ;
    localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PER_RELOAD = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    poll_state_t           r_state;
    poll_state_t           w_next;
    logic [PW-1:0]         r_per;
    logic                  r_tick;
    logic [TW-1:0]         r_to;
    logic [SNES_BTN_W-1:0] r_btn;
    logic                  r_err;
    logic                  w_in_xact;
    logic                  w_to_hit;
    logic [SNES_BTN_W-1:0] w_new;
    btn_edge_t             w_edge;
    logic                  w_load;

    assign w_in_xact = (r_state == S_RISE) || (r_state == S_BUSY);
    assign w_to_hit  = w_in_xact && (r_to == TO_LAST);

`ifdef SNES_POLL_CONNECT_DETECT_EN
    logic r_present;
    logic w_present;
    assign w_present   = (pad_buttons[15:12] == 4'h0) && (pad_buttons != 16'hFFFF);
    // an absent pad reads as all-released so held buttons emit release events
    assign w_new       = w_present ? pad_buttons : '0;
    assign pad_present = r_present;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_present <= 1'b0;
        else if (r_state == S_UPDATE) r_present <= w_present;
    end
`else
    assign w_new = pad_buttons;
`endif

    assign w_edge = btn_edges(r_btn, w_new);
    assign w_load = (r_state == S_UPDATE) && ((w_edge.pressed | w_edge.released) != '0);

    // Poll period runs off enable alone so transaction length never stretches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per  <= PER_RELOAD;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_per  <= PER_RELOAD;
            r_tick <= 1'b0;
        end else begin
            r_per <= (r_per == '0) ? PER_RELOAD : r_per - PW'(1);
            if (r_per == '0)
                r_tick <= 1'b1;
            else if (r_state == S_WAIT)
                r_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to  <= '0;
            r_btn <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_REQ)
                r_to <= '0;
            else if (w_in_xact && !w_to_hit)
                r_to <= r_to + TW'(1);
            if (w_to_hit)
                r_err <= 1'b1;
            if (r_state == S_UPDATE)
                r_btn <= w_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_next = S_WAIT;
            S_WAIT:   if (!enable) w_next = S_IDLE;
                      else if (r_tick) w_next = S_REQ;
            S_REQ:    w_next = S_RISE;
            S_RISE:   if (w_to_hit) w_next = S_WAIT;
                      else if (pad_busy) w_next = S_BUSY;
            S_BUSY:   if (w_to_hit) w_next = S_WAIT;
                      else if (!pad_busy) w_next = S_UPDATE;
            S_UPDATE: w_next = enable ? S_WAIT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        pad_rd    = 1'b0;
        poll_done = 1'b0;
        case (r_state)
            S_REQ:    pad_rd    = 1'b1;
            S_UPDATE: poll_done = 1'b1;
            default:  ;
        endcase
    end

    assign btn_state   = r_btn;
    assign timeout_err = r_err;

    snes_evt_reg u_evt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_pressed  (w_edge.pressed),
        .i_released (w_edge.released),
        .i_ready    (evt_ready),
        .o_valid    (evt_valid),
        .o_pressed  (evt_pressed),
        .o_released (evt_released)
    );

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Randomized bench for snes_poll_scheduler: a reactive gamepad model plus a transaction-timing
// and event-merge reference computed from tick arithmetic, checked every cycle.
module tb_snes_poll_scheduler;

    localparam int P  = 100;
    localparam int TO = 320;
    localparam int NX = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pad_busy = 1'b0;
    logic        evt_ready = 1'b0;
    logic [15:0] pad_buttons = '0;
    logic        pad_rd, evt_valid, timeout_err, poll_done;
    logic [15:0] btn_state, evt_pressed, evt_released;
`ifdef SNES_POLL_CONNECT_DETECT_EN
    logic        pad_present;
`endif

    snes_poll_scheduler #(.CLK_HZ(1000), .POLL_HZ(10), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pad_rd       (pad_rd),
        .pad_busy     (pad_busy),
        .pad_buttons  (pad_buttons),
        .btn_state    (btn_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_pressed  (evt_pressed),
        .evt_released (evt_released),
        .timeout_err  (timeout_err),
`ifdef SNES_POLL_CONNECT_DETECT_EN
        .pad_present  (pad_present),
`endif
        .poll_done    (poll_done)
    );

    always #5 clk = ~clk;

    int n_test = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_test++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // reference state: phase 0=off 1=waiting for tick 2=transaction in flight
    int          m_ph = 0, base = 0, next_tick = 0, wait_from = 0, rd_at = 0, upd_at = 0;
    int          cx = -1, idle = 0, obs_rd = 0, chk_a = -10, chk_m = -10;
    bit          m_to = 0, first = 0, rst_ph = 0, ld, fire;
    logic        e_rd = 0, e_pd = 0, e_v = 0, e_err = 0;
    logic [15:0] e_btn = '0, e_p = '0, e_r = '0, p, r;
    // current transaction plan, shared by the gamepad model and the reference
    int          pl_dly = 0, pl_l = 0;
    logic [15:0] pl_w = '0;
    bit          gp_act = 0;
    int          gp_b0 = 0, gp_l = 0;
    logic [15:0] wtab [6] = '{16'h0000, 16'h0100, 16'h0000, 16'h0001, 16'h0000, 16'h0002};

    task automatic plan(input int k);
        pl_dly = (k < 3) ? 0 : int'($urandom_range(0, 2));
        if (k < 3)
            pl_l = 50;
        else if (k == 18 || k == 11)
            pl_l = 60;
        else if (k == 7 || (k > 8 && $urandom_range(0, 11) == 0))
            pl_l = TO - pl_dly + 1;
        else if (k == 8 || $urandom_range(0, 7) == 0)
            pl_l = 250;
        else
            pl_l = int'($urandom_range(5, 60));
        if (k < 6)
            pl_w = wtab[k];
        else case ($urandom_range(0, 3))
            0:       pl_w = pl_w;
            1:       pl_w = pl_w ^ (16'h0001 << $urandom_range(0, 11));
            2:       pl_w = 16'($urandom) & 16'h0FFF;
            default: pl_w = 16'($urandom);
        endcase
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd",    32'(pad_rd), 32'd0);
        chk("rst_pd",    32'(poll_done), 32'd0);
        chk("rst_btn",   32'(btn_state), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;
        while (cx < NX && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (rst_ph) begin
                chk("mid_rst_rd",    32'(pad_rd), 32'd0);
                chk("mid_rst_pd",    32'(poll_done), 32'd0);
                chk("mid_rst_btn",   32'(btn_state), 32'd0);
                chk("mid_rst_valid", 32'(evt_valid), 32'd0);
                chk("mid_rst_evt",   32'({evt_pressed, evt_released}), 32'd0);
                chk("mid_rst_err",   32'(timeout_err), 32'd0);
                rst = 1'b0; rst_ph = 0; gp_act = 0; pad_busy = 1'b0;
                m_ph = 0; idle = 0; e_rd = 0; e_pd = 0; e_v = 0; e_err = 0;
                e_btn = '0; e_p = '0; e_r = '0;
                continue;
            end
            chk("pad_rd",    32'(pad_rd), 32'(e_rd));
            chk("poll_done", 32'(poll_done), 32'(e_pd));
            chk("evt_valid", 32'(evt_valid), 32'(e_v));
            if (e_v) begin
                chk("evt_pressed",  32'(evt_pressed), 32'(e_p));
                chk("evt_released", 32'(evt_released), 32'(e_r));
            end
            chk("btn_state",   32'(btn_state), 32'(e_btn));
            chk("timeout_err", 32'(timeout_err), 32'(e_err));
            if (pad_rd) begin
                if (first) chk("first_rd_lat", 32'(cyc - base), 32'(P + 1));
                first = 0; obs_rd = cyc;
            end
            if (poll_done && cx < 3) chk("poll_done_lat", 32'(cyc - obs_rd), 32'd52);
            if (cyc == chk_a) begin
                chk("pressA_p", 32'(evt_pressed), 32'h0100);
                chk("pressA_r", 32'(evt_released), 32'h0000);
                chk("pressA_btn", 32'(btn_state), 32'h0100);
            end
            if (cyc == chk_a + 1) chk("pressA_drop", 32'(evt_valid), 32'd0);
            if (cyc == chk_m) begin
                chk("merge_v", 32'(evt_valid), 32'd1);
                chk("merge_p", 32'(evt_pressed), 32'h0002);
                chk("merge_r", 32'(evt_released), 32'h0001);
            end

            // gamepad controller model reacting to the DUT's read strobe
            if (gp_act && cyc >= gp_b0 + gp_l) gp_act = 0;
            if (pad_rd && !gp_act) begin
                gp_act = 1; gp_b0 = cyc + 1 + pl_dly; gp_l = pl_l; pad_buttons = pl_w;
            end
            pad_busy = gp_act && cyc >= gp_b0 && cyc < gp_b0 + gp_l;

            if (cx <= 2)                 evt_ready = 1'b1;
            else if (cx <= 5)            evt_ready = 1'b0;
            else if ((cyc / 300) % 3 == 0) evt_ready = ($urandom_range(0, 7) == 0);
            else                         evt_ready = 1'($urandom_range(0, 1));

            if (m_ph == 2 && cx == 11 && cyc == rd_at + 5) enable = 1'b0;
            if (m_ph == 2 && cx == 18 && cyc == rd_at + 10) begin
                rst = 1'b1; enable = 1'b0; rst_ph = 1;
                continue;
            end
            if (!enable && m_ph == 0) begin
                idle++;
                if (idle >= 10) begin
                    enable = 1'b1; idle = 0; base = cyc; first = 1;
                    next_tick = cyc + P; wait_from = cyc + 1; m_ph = 1;
                end
            end

            // reference: what the outputs must be during the next cycle
            e_rd = 0; e_pd = 0; ld = 0;
            fire = e_v && evt_ready;
            if (m_ph == 1) begin
                if (!enable) m_ph = 0;
                else if (cyc >= next_tick && cyc >= wait_from) begin
                    e_rd = 1; rd_at = cyc + 1;
                    next_tick = base + ((cyc - base) / P + 1) * P;
                    cx++; plan(cx);
                    m_to   = (rd_at + 1 + pl_dly + pl_l) >= (rd_at + TO);
                    upd_at = rd_at + 1 + pl_dly + pl_l + 1;
                    m_ph = 2;
                end
            end else if (m_ph == 2) begin
                if (m_to) begin
                    if (cyc == rd_at + TO) begin e_err = 1; wait_from = cyc + 1; m_ph = 1; end
                end else begin
                    if (cyc == upd_at - 1) e_pd = 1;
                    if (cyc == upd_at) begin
                        p = pl_w & ~e_btn; r = ~pl_w & e_btn; e_btn = pl_w;
                        ld = (p | r) != 16'h0; wait_from = cyc + 1; m_ph = 1;
                        if (cx == 1) chk_a = cyc + 1;
                        if (cx == 5) chk_m = cyc + 1;
                    end
                end
            end
            if (ld) begin
                if (!e_v || evt_ready) begin
                    e_p = p; e_r = r;
                end else begin
                    e_p = (e_p & ~r) | p; e_r = (e_r & ~p) | r;
                end
                e_v = 1;
            end else if (fire) e_v = 0;
        end
        if (cx < NX) chk("cycle_budget", 32'(cx), 32'(NX));
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

// File: doc/snes_poll_scheduler.md
Name: snes_poll_scheduler

Overview:
- Sequences the SNES gamepad controller: issues `rd` on a fixed poll period and waits out the transaction via `busy`.
- Captures the 16-bit active-high button word and derives pressed/released edge masks.
- Delivers edge events to a downstream consumer (game logic, UART bridge) over a valid/ready handshake.
- Sits between the gamepad controller and all button consumers.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- POLL_HZ, 60, poll rate; PERIOD = CLK_HZ/POLL_HZ cycles (integer division). PERIOD must be >= 2.
- TIMEOUT, 32768, maximum cycles allowed for one gamepad transaction (nominal 20400 at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  polling enable, level.
- pad_rd  out  1  read strobe to gamepad controller, one cycle.
- pad_busy  in  1  gamepad controller busy.
- pad_buttons  in  16  active-high buttons from gamepad controller.
- btn_state  out  16  last captured button word.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_pressed  out  16  bits that went 0->1.
- evt_released  out  16  bits that went 1->0.
- timeout_err  out  1  sticky; set on transaction timeout.
- poll_done  out  1  one-cycle pulse per completed poll.

Behaviour:
- Reset values: pad_rd=0, btn_state=0, evt_valid=0, evt_pressed=0, evt_released=0, timeout_err=0, poll_done=0, period counter=PERIOD-1, tick_pend=0, FSM=S_IDLE.
- Period counter runs only while enable=1. It decrements to 0, then reloads PERIOD-1 and sets tick_pend. Width is $clog2(PERIOD). The period is independent of transaction length.
- FSM states:
  - S_IDLE: enable=0. Counter is held at PERIOD-1 and tick_pend is cleared. On enable=1, go to S_WAIT. The first read launches PERIOD cycles after enable rises.
  - S_WAIT: when tick_pend=1, clear tick_pend and go to S_REQ. When enable=0, go to S_IDLE.
  - S_REQ: pad_rd=1 for exactly this cycle, then go to S_RISE. The timeout counter clears.
  - S_RISE: wait for pad_busy=1, then go to S_BUSY.
  - S_BUSY: wait for pad_busy=0, then go to S_UPDATE.
  - S_UPDATE: sample pad_buttons; compute pressed=new&~old and released=~new&old with old=btn_state; write btn_state=new; pulse poll_done. Go to S_WAIT, or to S_IDLE if enable=0.
- Timeout counter runs in S_RISE and S_BUSY. If it reaches TIMEOUT-1, set timeout_err, skip the capture (btn_state unchanged, no poll_done), and return to S_WAIT. timeout_err clears only on reset.
- A tick arriving during a transaction sets tick_pend. That read then launches on the first S_WAIT cycle. Multiple ticks within one transaction collapse to one.
- enable=0 mid-transaction: the transaction completes and its update is published, then the FSM goes to S_IDLE.
- Event output:
  - Loaded in S_UPDATE only if (pressed|released)!=0.
  - If evt_valid=0, or evt_valid=1 with evt_ready=1 in the same cycle: load the new masks, evt_valid=1.
  - If evt_valid=1 and evt_ready=0: merge. pressed_acc = (pressed_acc & ~released) | pressed; released_acc = (released_acc & ~pressed) | released. A press then release of the same bit before acceptance reports released only.
  - evt_valid drops the cycle after evt_valid&&evt_ready when no new load occurs.
  - Outputs hold stable while evt_valid=1 and evt_ready=0, except for merges.
- Reset mid-transaction: immediate return to reset values. The gamepad controller shares rst.

Optional Feature:
- Macro SNES_POLL_CONNECT_DETECT_EN.
- Defined:
  - Adds output `pad_present` (1 bit, reset 0).
  - In S_UPDATE, pad_present = (pad_buttons[15:12]==4'h0) && (pad_buttons!=16'hFFFF).
  - While pad_present=0, btn_state is forced to 0 and the word is treated as all-released for edge computation.
  - A 1->0 transition of pad_present therefore emits released for all held bits.
- Undefined: no port; pad_buttons is used directly.

Decomposition:
- Shared package snes_pkg holds:
  - FSM state encoding (S_IDLE, S_WAIT, S_REQ, S_RISE, S_BUSY, S_UPDATE; 3 bits).
  - SNES_BTN_W=16.
  - Button bit index constants (B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11).
- One natural sub-module: snes_evt_reg, holding the event merge/valid-ready register.

Test Plan:
- Basic poll (CLK_HZ=1000, POLL_HZ=10, gamepad model busy 50 cycles): enable=1 at t0 -> pad_rd pulses at cycles 100, 200, 300; poll_done 52 cycles after each pad_rd.
- Press A: model returns 16'h0100 after 16'h0000 -> evt_valid=1, evt_pressed=16'h0100, evt_released=0, btn_state=16'h0100; evt_ready=1 -> evt_valid=0 next cycle.
- Merge with consumer stalled (evt_ready=0): words 0x0001 -> 0x0000 -> 0x0002 -> evt_pressed=16'h0002, evt_released=16'h0001 after the third poll.
- Timeout (TIMEOUT=64): model holds busy high -> timeout_err=1 at 64 cycles after busy checking starts; btn_state unchanged; next pad_rd still issued on the next tick.
- Long transaction (busy 250 cycles, PERIOD=100): exactly one pad_rd per completed transaction, launched on the cycle after S_UPDATE. Assert rst mid-S_BUSY -> all outputs 0 next cycle.
